// File: rtl/alt_counter_pkg.sv
// Shared types and helpers for the alt_counter_bank counter lanes.
package alt_counter_pkg;

    typedef enum logic {
        CNT_WRAP     = 1'b0,
        CNT_SATURATE = 1'b1
    } counter_mode_e;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } counter_op_e;

    // LSB position of a lane inside a packed per-lane bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    // Maps the integer saturate parameter onto the mode enum.
    function automatic counter_mode_e to_mode(input int unsigned saturate);
        return (saturate != 0) ? CNT_SATURATE : CNT_WRAP;
    endfunction

endpackage

// File: rtl/alt_counter_lane.sv
// One counter channel: load/incr/decr with step, wrap or saturate,
// registered zero/max flags, sticky overflow/underflow and threshold compare.
module alt_counter_lane
    import alt_counter_pkg::*;
#(
    parameter int unsigned        C_WIDTH      = 8,
    parameter int unsigned        C_STEP_WIDTH = 4,
    parameter counter_mode_e      C_MODE       = CNT_WRAP,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clken_i,
    input  logic                    load_i,
    input  logic [C_WIDTH-1:0]      load_value_i,
    input  logic                    incr_i,
    input  logic                    decr_i,
    input  logic [C_STEP_WIDTH-1:0] step_i,
    input  logic                    clear_flags_i,
    input  logic [C_WIDTH-1:0]      threshold_i,
    output logic [C_WIDTH-1:0]      count_o,
    output logic                    is_zero_o,
    output logic                    is_max_o,
    output logic                    at_thresh_o,
    output logic                    ovf_o,
    output logic                    udf_o
);

    localparam int unsigned        W1      = C_WIDTH + 1;
    localparam logic [C_WIDTH-1:0] MAX_VAL = '1;

    counter_op_e        op_c;
    logic [W1-1:0]      sum_c;
    logic [W1-1:0]      diff_c;

    logic [C_WIDTH-1:0] count_q,   count_d;
    logic               is_zero_q, is_zero_d;
    logic               is_max_q,  is_max_d;
    logic               ovf_q,     ovf_d;
    logic               udf_q,     udf_d;

    // Decode strobes into a single op; load dominates, incr+decr cancels.
    always_comb begin
        op_c = OP_HOLD;
        if (load_i) begin
            op_c = OP_LOAD;
        end else if (incr_i && !decr_i) begin
            op_c = OP_INC;
        end else if (decr_i && !incr_i) begin
            op_c = OP_DEC;
        end
    end

    // The extra top bit is the carry (sum) or borrow (difference).
    assign sum_c  = W1'(count_q) + W1'(step_i);
    assign diff_c = W1'(count_q) - W1'(step_i);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        if (clken_i) begin
            // Clear first so a same-cycle event re-sets the flag.
            if (clear_flags_i) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
            end

            case (op_c)
                OP_LOAD: begin
                    count_d = load_value_i;
                end
                OP_INC: begin
                    if (sum_c[C_WIDTH]) begin
                        ovf_d   = 1'b1;
                        count_d = (C_MODE == CNT_SATURATE) ? MAX_VAL : sum_c[C_WIDTH-1:0];
                    end else begin
                        count_d = sum_c[C_WIDTH-1:0];
                    end
                end
                OP_DEC: begin
                    if (diff_c[C_WIDTH]) begin
                        udf_d   = 1'b1;
                        count_d = (C_MODE == CNT_SATURATE) ? '0 : diff_c[C_WIDTH-1:0];
                    end else begin
                        count_d = diff_c[C_WIDTH-1:0];
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end

        // Flags derive from the next count so they register on the same edge.
        is_zero_d = (count_d == '0);
        is_max_d  = (count_d == MAX_VAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= C_INIT;
            is_zero_q <= (C_INIT == '0);
            is_max_q  <= (C_INIT == MAX_VAL);
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            is_zero_q <= is_zero_d;
            is_max_q  <= is_max_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign count_o     = count_q;
    assign is_zero_o   = is_zero_q;
    assign is_max_o    = is_max_q;
    assign ovf_o       = ovf_q;
    assign udf_o       = udf_q;
    assign at_thresh_o = (count_q >= threshold_i);

endmodule

// File: rtl/alt_counter_bank.sv
// Bank of independent up/down counter lanes sharing clock, reset and enable.
module alt_counter_bank
    import alt_counter_pkg::*;
#(
    parameter int unsigned        C_CHANNELS   = 4,
    parameter int unsigned        C_WIDTH      = 8,
    parameter int unsigned        C_STEP_WIDTH = 4,
    parameter int unsigned        C_SATURATE   = 0,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clken,
    input  logic [C_CHANNELS-1:0]            load,
    input  logic [C_CHANNELS*C_WIDTH-1:0]    load_value,
    input  logic [C_CHANNELS-1:0]            incr,
    input  logic [C_CHANNELS-1:0]            decr,
    input  logic [C_CHANNELS*C_STEP_WIDTH-1:0] step,
    input  logic [C_CHANNELS-1:0]            clear_flags,
    input  logic [C_WIDTH-1:0]               threshold,
    output logic [C_CHANNELS*C_WIDTH-1:0]    count,
    output logic [C_CHANNELS-1:0]            is_zero,
    output logic [C_CHANNELS-1:0]            is_max,
    output logic [C_CHANNELS-1:0]            at_thresh,
    output logic [C_CHANNELS-1:0]            ovf,
    output logic [C_CHANNELS-1:0]            udf
);

    localparam counter_mode_e MODE = to_mode(C_SATURATE);

    // One lane per channel, each on its own slice of the packed buses.
    for (genvar i = 0; i < C_CHANNELS; i++) begin : g_lane
        localparam int unsigned CNT_LSB  = lane_lsb(i, C_WIDTH);
        localparam int unsigned STEP_LSB = lane_lsb(i, C_STEP_WIDTH);

        alt_counter_lane #(
            .C_WIDTH      (C_WIDTH),
            .C_STEP_WIDTH (C_STEP_WIDTH),
            .C_MODE       (MODE),
            .C_INIT       (C_INIT)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .clken_i       (clken),
            .load_i        (load[i]),
            .load_value_i  (load_value[CNT_LSB +: C_WIDTH]),
            .incr_i        (incr[i]),
            .decr_i        (decr[i]),
            .step_i        (step[STEP_LSB +: C_STEP_WIDTH]),
            .clear_flags_i (clear_flags[i]),
            .threshold_i   (threshold),
            .count_o       (count[CNT_LSB +: C_WIDTH]),
            .is_zero_o     (is_zero[i]),
            .is_max_o      (is_max[i]),
            .at_thresh_o   (at_thresh[i]),
            .ovf_o         (ovf[i]),
            .udf_o         (udf[i])
        );
    end

endmodule

// File: tb/tb_alt_counter_bank.sv
// Self-checking bench: wrap and saturate banks driven in parallel against an arithmetic model.
module tb_alt_counter_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clken;
    logic [3:0]  load;
    logic [31:0] load_value;
    logic [3:0]  incr;
    logic [3:0]  decr;
    logic [15:0] step;
    logic [3:0]  clear_flags;
    logic [7:0]  threshold;

    logic [31:0] cnt_w, cnt_s;
    logic [3:0]  zro_w, zro_s, max_w, max_s, thr_w, thr_s, ovf_w, ovf_s, udf_w, udf_s;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: [mode][lane], mode 0 = wrap, 1 = saturate.
    int mc [2][4];
    bit mo [2][4];
    bit mu [2][4];

    always #5 clk = ~clk;

    alt_counter_bank #(.C_CHANNELS(4), .C_WIDTH(8), .C_STEP_WIDTH(4), .C_SATURATE(0), .C_INIT(8'd0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clken(clken), .load(load), .load_value(load_value),
        .incr(incr), .decr(decr), .step(step), .clear_flags(clear_flags), .threshold(threshold),
        .count(cnt_w), .is_zero(zro_w), .is_max(max_w), .at_thresh(thr_w), .ovf(ovf_w), .udf(udf_w));

    alt_counter_bank #(.C_CHANNELS(4), .C_WIDTH(8), .C_STEP_WIDTH(4), .C_SATURATE(1), .C_INIT(8'd0)) u_sat (
        .clk(clk), .rst_n(rst_n), .clken(clken), .load(load), .load_value(load_value),
        .incr(incr), .decr(decr), .step(step), .clear_flags(clear_flags), .threshold(threshold),
        .count(cnt_s), .is_zero(zro_s), .is_max(max_s), .at_thresh(thr_s), .ovf(ovf_s), .udf(udf_s));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: plain integer arithmetic on each lane.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++)
                for (int l = 0; l < 4; l++) begin
                    mc[m][l] <= 0; mo[m][l] <= 1'b0; mu[m][l] <= 1'b0;
                end
        end else if (clken) begin
            for (int m = 0; m < 2; m++)
                for (int l = 0; l < 4; l++) begin
                    int v, st;
                    bit o, u;
                    v  = mc[m][l];
                    st = int'(step[l*4 +: 4]);
                    o  = clear_flags[l] ? 1'b0 : mo[m][l];
                    u  = clear_flags[l] ? 1'b0 : mu[m][l];
                    if (load[l]) begin
                        v = int'(load_value[l*8 +: 8]);
                    end else if (incr[l] && !decr[l]) begin
                        v = v + st;
                        if (v > 255) begin o = 1'b1; v = (m == 0) ? v - 256 : 255; end
                    end else if (decr[l] && !incr[l]) begin
                        v = v - st;
                        if (v < 0) begin u = 1'b1; v = (m == 0) ? v + 256 : 0; end
                    end
                    mc[m][l] <= v; mo[m][l] <= o; mu[m][l] <= u;
                end
        end
    end

    // Compare every lane of both banks shortly after each rising edge.
    always @(posedge clk) begin
        logic [31:0] c;
        logic [3:0]  z, x, t, o, u;
        #2;
        for (int m = 0; m < 2; m++) begin
            c = (m == 0) ? cnt_w : cnt_s;
            z = (m == 0) ? zro_w : zro_s;
            x = (m == 0) ? max_w : max_s;
            t = (m == 0) ? thr_w : thr_s;
            o = (m == 0) ? ovf_w : ovf_s;
            u = (m == 0) ? udf_w : udf_s;
            for (int l = 0; l < 4; l++) begin
                check($sformatf("m%0d_l%0d_count", m, l), int'(c[l*8 +: 8]), mc[m][l]);
                check($sformatf("m%0d_l%0d_is_zero", m, l), int'(z[l]), int'(mc[m][l] == 0));
                check($sformatf("m%0d_l%0d_is_max", m, l), int'(x[l]), int'(mc[m][l] == 255));
                check($sformatf("m%0d_l%0d_at_thresh", m, l), int'(t[l]), int'(mc[m][l] >= int'(threshold)));
                check($sformatf("m%0d_l%0d_ovf", m, l), int'(o[l]), int'(mo[m][l]));
                check($sformatf("m%0d_l%0d_udf", m, l), int'(u[l]), int'(mu[m][l]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        load = '0; load_value = '0; incr = '0; decr = '0; step = '0; clear_flags = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clken = 1'b1; threshold = 8'd200;
        idle();
        tick(); tick();
        check("rst_count", int'(cnt_w), 0);
        check("rst_is_zero", int'(zro_w), 15);
        check("rst_is_max", int'(max_s), 0);
        check("rst_ovf_udf", int'({ovf_w, udf_w, ovf_s, udf_s}), 0);
        rst_n = 1'b1;
        tick();

        // Overflow: 250 + 9
        load = 4'b0001; load_value[7:0] = 8'd250; tick();
        idle(); incr = 4'b0001; step[3:0] = 4'd9; tick();
        check("wrap_ovf_count", int'(cnt_w[7:0]), 3);
        check("wrap_ovf_flag", int'(ovf_w[0]), 1);
        check("sat_ovf_count", int'(cnt_s[7:0]), 255);
        check("sat_ovf_is_max", int'(max_s[0]), 1);
        check("sat_ovf_flag", int'(ovf_s[0]), 1);

        // Underflow: 3 - 5 (wrap), 255 - 5 (sat)
        idle(); decr = 4'b0001; step[3:0] = 4'd5; tick();
        check("wrap_udf_count", int'(cnt_w[7:0]), 254);
        check("wrap_udf_flag", int'(udf_w[0]), 1);
        check("sat_dec_count", int'(cnt_s[7:0]), 250);

        // Exact landing on zero
        idle(); load = 4'b0001; load_value[7:0] = 8'd4; tick();
        idle(); decr = 4'b0001; step[3:0] = 4'd4; tick();
        check("sat_land0_count", int'(cnt_s[7:0]), 0);
        check("sat_land0_is_zero", int'(zro_s[0]), 1);
        check("sat_land0_udf", int'(udf_s[0]), 0);
        check("wrap_land0_udf_kept", int'(udf_w[0]), 1);

        // incr and decr together hold
        idle(); load = 4'b0001; load_value[7:0] = 8'd10; tick();
        idle(); incr = 4'b0001; decr = 4'b0001; step[3:0] = 4'd7; tick();
        check("both_hold", int'(cnt_w[7:0]), 10);

        // load beats incr
        idle(); load = 4'b0001; load_value[7:0] = 8'd20; incr = 4'b0001; step[3:0] = 4'd7; tick();
        check("load_wins", int'(cnt_s[7:0]), 20);

        // clear_flags with a same-cycle overflow
        idle(); load = 4'b0001; load_value[7:0] = 8'd250; tick();
        idle(); incr = 4'b0001; step[3:0] = 4'd9; clear_flags = 4'b0001; tick();
        check("clr_event_ovf", int'(ovf_w[0]), 1);
        check("clr_event_udf", int'(udf_w[0]), 0);
        idle(); clear_flags = 4'b0001; tick();
        check("clr_only_ovf", int'(ovf_w[0]), 0);

        // clken low: everything holds
        idle(); load = 4'b0001; load_value[7:0] = 8'd250; tick();
        idle(); incr = 4'b0001; step[3:0] = 4'd9; tick();
        clken = 1'b0; load = 4'b0001; load_value[7:0] = 8'd77; clear_flags = 4'b0001;
        step[3:0] = 4'd1;
        tick(); tick(); tick();
        check("clken_hold_count", int'(cnt_w[7:0]), 3);
        check("clken_hold_ovf", int'(ovf_w[0]), 1);
        idle(); clken = 1'b1; incr = 4'b0001; step[3:0] = 4'd1; tick();
        check("clken_resume", int'(cnt_w[7:0]), 4);

        // Threshold compare on lane 1
        idle(); threshold = 8'd100; load = 4'b0010; load_value[15:8] = 8'd98; tick();
        check("thr_98", int'(thr_w[1]), 0);
        idle(); incr = 4'b0010; step[7:4] = 4'd1; tick();
        check("thr_99", int'(thr_w[1]), 0);
        tick();
        check("thr_100", int'(thr_w[1]), 1);
        idle();
        threshold = 8'd101; #1;
        check("thr_101_now", int'(thr_w[1]), 0);
        threshold = 8'd50; #1;
        check("thr_50_wrap", int'(thr_w), 2);
        check("thr_50_sat", int'(thr_s), 3);
        tick();

        // Asynchronous reset mid-count
        load = 4'b0001; load_value[7:0] = 8'd37; tick();
        idle(); #3; rst_n = 1'b0; #1;
        check("async_rst_count", int'(cnt_w), 0);
        check("async_rst_is_zero", int'(zro_s), 15);
        check("async_rst_ovf", int'(ovf_w | ovf_s), 0);
        tick(); rst_n = 1'b1; tick();

        // Mixed traffic on all lanes, checked by the model
        for (int i = 0; i < 80; i++) begin
            clken       = ($urandom_range(0, 7) != 0);
            load        = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            load_value  = $urandom;
            incr        = 4'($urandom);
            decr        = 4'($urandom);
            step        = 16'($urandom);
            clear_flags = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            threshold   = 8'($urandom);
            tick();
        end
        idle();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
